// File: rtl/acc_req_arbiter.sv
// Round-robin arbiter sharing one accelerator request/response port among NumReq
// requesters, with grant lock, index-tagged IDs and per-requester in-flight throttling.
module acc_req_arbiter #(
  parameter int unsigned NumReq         = 1,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AccAddrWidth   = 1,
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          AssertEn       = 1'b1,
  localparam int unsigned IdxWidth      = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned IdWidth       = 5 + IdxWidth,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NumReq-1:0]                       slv_req_valid_i,
  output logic [NumReq-1:0]                       slv_req_ready_o,
  input  logic [NumReq-1:0][AccAddrWidth-1:0]     slv_req_addr_i,
  input  logic [NumReq-1:0][31:0]                 slv_req_data_op_i,
  input  logic [NumReq-1:0][2:0][DataWidth-1:0]   slv_req_data_arg_i,
  input  logic [NumReq-1:0][4:0]                  slv_req_id_i,
  output logic                                    mst_req_valid_o,
  input  logic                                    mst_req_ready_i,
  output logic [AccAddrWidth-1:0]                 mst_req_addr_o,
  output logic [31:0]                             mst_req_data_op_o,
  output logic [2:0][DataWidth-1:0]               mst_req_data_arg_o,
  output logic [IdWidth-1:0]                      mst_req_id_o,
  input  logic                                    mst_rsp_valid_i,
  output logic                                    mst_rsp_ready_o,
  input  logic [IdWidth-1:0]                      mst_rsp_id_i,
  input  logic [DataWidth-1:0]                    mst_rsp_data_i,
  input  logic                                    mst_rsp_error_i,
  output logic [NumReq-1:0]                       slv_rsp_valid_o,
  input  logic [NumReq-1:0]                       slv_rsp_ready_i,
  output logic [NumReq-1:0][4:0]                  slv_rsp_id_o,
  output logic [NumReq-1:0][DataWidth-1:0]        slv_rsp_data_o,
  output logic [NumReq-1:0]                       slv_rsp_error_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  logic [IdxWidth-1:0]               rr_ptr_reg, rr_ptr_next;
  logic                              lock_reg, lock_next;
  logic [IdxWidth-1:0]               lock_idx_reg, lock_idx_next;
  logic [NumReq-1:0][CntWidth-1:0]   cnt_reg;

  logic [NumReq-1:0]   eligible;
  logic [IdxWidth-1:0] rr_grant;
  logic                rr_found;
  logic [IdxWidth-1:0] grant;
  logic                req_hs;
  logic [IdxWidth-1:0] rsp_idx;
  logic                rsp_in_range;

  genvar gi;

  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_elig
      assign eligible[gi] = slv_req_valid_i[gi] && (cnt_reg[gi] < CntMax);
    end
  endgenerate

  // First eligible lane scanning upward from rr_ptr with wrap.
  always_comb begin
    int unsigned         cand;
    logic [IdxWidth-1:0] cand_idx;
    rr_grant = rr_ptr_reg;
    rr_found = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      cand_idx = IdxWidth'(cand);
      if (!rr_found && eligible[cand_idx]) begin
        rr_found = 1'b1;
        rr_grant = cand_idx;
      end
    end
  end

  assign grant           = lock_reg ? lock_idx_reg : rr_grant;
  assign mst_req_valid_o = lock_reg ? slv_req_valid_i[lock_idx_reg] : rr_found;
  assign req_hs          = mst_req_valid_o && mst_req_ready_i;

  assign mst_req_addr_o     = slv_req_addr_i[grant];
  assign mst_req_data_op_o  = slv_req_data_op_i[grant];
  assign mst_req_data_arg_o = slv_req_data_arg_i[grant];
  assign mst_req_id_o       = {grant, slv_req_id_i[grant]};

  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_req_ready
      assign slv_req_ready_o[gi] = (grant == IdxWidth'(gi)) && mst_req_ready_i && eligible[gi];
    end
  endgenerate

  always_comb begin
    rr_ptr_next   = rr_ptr_reg;
    lock_next     = lock_reg;
    lock_idx_next = lock_idx_reg;
    if (mst_req_valid_o && !mst_req_ready_i) begin
      lock_next     = 1'b1;
      lock_idx_next = grant;
    end else if (req_hs) begin
      lock_next   = 1'b0;
      rr_ptr_next = (int'(grant) == int'(NumReq) - 1) ? '0 : grant + IdxWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_reg   <= '0;
      lock_reg     <= 1'b0;
      lock_idx_reg <= '0;
    end else begin
      rr_ptr_reg   <= rr_ptr_next;
      lock_reg     <= lock_next;
      lock_idx_reg <= lock_idx_next;
    end
  end

  // Responses carrying an index beyond NumReq are accepted and discarded.
  assign rsp_idx         = mst_rsp_id_i[IdWidth-1 -: IdxWidth];
  assign rsp_in_range    = int'(rsp_idx) < int'(NumReq);
  assign mst_rsp_ready_o = rsp_in_range ? slv_rsp_ready_i[rsp_idx] : 1'b1;

  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_lane
      logic                inc, dec;
      logic [CntWidth-1:0] cnt_next;

      assign slv_rsp_valid_o[gi] = mst_rsp_valid_i && rsp_in_range && (rsp_idx == IdxWidth'(gi));
      assign slv_rsp_id_o[gi]    = mst_rsp_id_i[4:0];
      assign slv_rsp_data_o[gi]  = mst_rsp_data_i;
      assign slv_rsp_error_o[gi] = mst_rsp_error_i;

      assign inc = req_hs && (grant == IdxWidth'(gi));
      assign dec = slv_rsp_valid_o[gi] && slv_rsp_ready_i[gi];

      always_comb begin
        cnt_next = cnt_reg[gi];
        if (inc && !dec) begin
          cnt_next = cnt_reg[gi] + CntWidth'(1);
        end else if (dec && !inc && (cnt_reg[gi] != '0)) begin
          cnt_next = cnt_reg[gi] - CntWidth'(1);
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_reg[gi] <= '0;
        end else begin
          cnt_reg[gi] <= cnt_next;
        end
      end

      always @(posedge clk_i) begin
        if (AssertEn && rst_ni) begin
          assert (!(dec && !inc && (cnt_reg[gi] == '0)));
        end
      end
    end
  endgenerate

  always @(posedge clk_i) begin
    if (AssertEn && rst_ni) begin
      assert (!(mst_rsp_valid_i && !rsp_in_range));
    end
  end

endmodule

// File: tb/tb_acc_req_arbiter.sv
// Directed checks of acc_req_arbiter: a 4-lane instance with MaxOutstanding=2
// and a 3-lane instance for out-of-range response and counter-floor behaviour.
module tb_acc_req_arbiter;

  logic clk;
  logic rst_n, b_rst_n;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NumReq=4, MaxOutstanding=2
  logic [3:0]            a_req_valid, a_req_ready;
  logic [3:0][0:0]       a_req_addr;
  logic [3:0][31:0]      a_req_op;
  logic [3:0][2:0][31:0] a_req_arg;
  logic [3:0][4:0]       a_req_id;
  logic                  a_mst_req_valid, a_mst_req_ready;
  logic [0:0]            a_mst_req_addr;
  logic [31:0]           a_mst_req_op;
  logic [2:0][31:0]      a_mst_req_arg;
  logic [6:0]            a_mst_req_id;
  logic                  a_mst_rsp_valid, a_mst_rsp_ready;
  logic [6:0]            a_mst_rsp_id;
  logic [31:0]           a_mst_rsp_data;
  logic                  a_mst_rsp_err;
  logic [3:0]            a_rsp_valid, a_rsp_ready;
  logic [3:0][4:0]       a_rsp_id;
  logic [3:0][31:0]      a_rsp_data;
  logic [3:0]            a_rsp_err;

  acc_req_arbiter #(
    .NumReq(4), .DataWidth(32), .AccAddrWidth(1), .MaxOutstanding(2), .AssertEn(1'b1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_valid_i(a_req_valid), .slv_req_ready_o(a_req_ready),
    .slv_req_addr_i(a_req_addr), .slv_req_data_op_i(a_req_op),
    .slv_req_data_arg_i(a_req_arg), .slv_req_id_i(a_req_id),
    .mst_req_valid_o(a_mst_req_valid), .mst_req_ready_i(a_mst_req_ready),
    .mst_req_addr_o(a_mst_req_addr), .mst_req_data_op_o(a_mst_req_op),
    .mst_req_data_arg_o(a_mst_req_arg), .mst_req_id_o(a_mst_req_id),
    .mst_rsp_valid_i(a_mst_rsp_valid), .mst_rsp_ready_o(a_mst_rsp_ready),
    .mst_rsp_id_i(a_mst_rsp_id), .mst_rsp_data_i(a_mst_rsp_data),
    .mst_rsp_error_i(a_mst_rsp_err),
    .slv_rsp_valid_o(a_rsp_valid), .slv_rsp_ready_i(a_rsp_ready),
    .slv_rsp_id_o(a_rsp_id), .slv_rsp_data_o(a_rsp_data), .slv_rsp_error_o(a_rsp_err)
  );

  // Instance B: NumReq=3, protocol checks disabled so bad indices can be driven
  logic [2:0]            b_req_valid, b_req_ready;
  logic [2:0][0:0]       b_req_addr;
  logic [2:0][31:0]      b_req_op;
  logic [2:0][2:0][31:0] b_req_arg;
  logic [2:0][4:0]       b_req_id;
  logic                  b_mst_req_valid, b_mst_req_ready;
  logic [0:0]            b_mst_req_addr;
  logic [31:0]           b_mst_req_op;
  logic [2:0][31:0]      b_mst_req_arg;
  logic [6:0]            b_mst_req_id;
  logic                  b_mst_rsp_valid, b_mst_rsp_ready;
  logic [6:0]            b_mst_rsp_id;
  logic [31:0]           b_mst_rsp_data;
  logic                  b_mst_rsp_err;
  logic [2:0]            b_rsp_valid, b_rsp_ready;
  logic [2:0][4:0]       b_rsp_id;
  logic [2:0][31:0]      b_rsp_data;
  logic [2:0]            b_rsp_err;

  acc_req_arbiter #(
    .NumReq(3), .DataWidth(32), .AccAddrWidth(1), .MaxOutstanding(4), .AssertEn(1'b0)
  ) dut_b (
    .clk_i(clk), .rst_ni(b_rst_n),
    .slv_req_valid_i(b_req_valid), .slv_req_ready_o(b_req_ready),
    .slv_req_addr_i(b_req_addr), .slv_req_data_op_i(b_req_op),
    .slv_req_data_arg_i(b_req_arg), .slv_req_id_i(b_req_id),
    .mst_req_valid_o(b_mst_req_valid), .mst_req_ready_i(b_mst_req_ready),
    .mst_req_addr_o(b_mst_req_addr), .mst_req_data_op_o(b_mst_req_op),
    .mst_req_data_arg_o(b_mst_req_arg), .mst_req_id_o(b_mst_req_id),
    .mst_rsp_valid_i(b_mst_rsp_valid), .mst_rsp_ready_o(b_mst_rsp_ready),
    .mst_rsp_id_i(b_mst_rsp_id), .mst_rsp_data_i(b_mst_rsp_data),
    .mst_rsp_error_i(b_mst_rsp_err),
    .slv_rsp_valid_o(b_rsp_valid), .slv_rsp_ready_i(b_rsp_ready),
    .slv_rsp_id_o(b_rsp_id), .slv_rsp_data_o(b_rsp_data), .slv_rsp_error_o(b_rsp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drv(input logic [3:0] v, input logic rdy);
    a_req_valid     = v;
    a_mst_req_ready = rdy;
  endtask

  task automatic a_rsp(input logic v, input logic [6:0] id, input logic [3:0] rdy);
    a_mst_rsp_valid = v;
    a_mst_rsp_id    = id;
    a_rsp_ready     = rdy;
  endtask

  task automatic b_rsp(input logic v, input logic [6:0] id, input logic [2:0] rdy);
    b_mst_rsp_valid = v;
    b_mst_rsp_id    = id;
    b_rsp_ready     = rdy;
  endtask

  logic [1:0] exp_g [5];
  logic [1:0] g;
  logic [6:0] exp_id;

  initial begin
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst_n = 1'b0;
    b_rst_n = 1'b0;
    a_drv(4'b0000, 1'b0);
    a_rsp(1'b0, 7'd0, 4'b0000);
    a_mst_rsp_data = 32'h0;
    a_mst_rsp_err = 1'b0;
    b_req_valid = 3'b000;
    b_mst_req_ready = 1'b0;
    b_rsp(1'b0, 7'd0, 3'b000);
    b_mst_rsp_data = 32'h0;
    b_mst_rsp_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_req_op[i]   = 32'hA000_0000 + 32'(i);
      a_req_addr[i] = 1'(i);
      a_req_id[i]   = 5'(10 + i);
      for (int j = 0; j < 3; j++) a_req_arg[i][j] = 32'(i * 16 + j);
    end
    for (int i = 0; i < 3; i++) begin
      b_req_op[i]   = 32'hB000_0000 + 32'(i);
      b_req_addr[i] = 1'(i);
      b_req_id[i]   = 5'(20 + i);
      for (int j = 0; j < 3; j++) b_req_arg[i][j] = 32'(i * 16 + j);
    end

    // Reset with idle inputs: every valid/ready output low
    #2;
    chk("rst_mst_req_valid", 64'(a_mst_req_valid), 64'(1'b0));
    chk("rst_slv_req_ready", 64'(a_req_ready), 64'(4'b0000));
    chk("rst_mst_rsp_ready", 64'(a_mst_rsp_ready), 64'(1'b0));
    chk("rst_slv_rsp_valid", 64'(a_rsp_valid), 64'(4'b0000));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    b_rst_n = 1'b1;

    // All lanes valid, always ready, responses returned in the same cycle
    for (int k = 0; k < 5; k++) begin
      cyc();
      g = exp_g[k];
      a_drv(4'b1111, 1'b1);
      a_rsp(1'b1, {g, 5'(10 + int'(g))}, 4'b1111);
      #1;
      exp_id = {g, 5'(10 + int'(g))};
      chk("rr_valid", 64'(a_mst_req_valid), 64'(1'b1));
      chk("rr_id", 64'(a_mst_req_id), 64'(exp_id));
      chk("rr_ready", 64'(a_req_ready), 64'(4'b0001 << g));
    end

    // Lane 2 stalled by downstream; lane 0 arrives meanwhile
    cyc(); a_drv(4'b0100, 1'b0); a_rsp(1'b0, 7'd0, 4'b1111); #1;
    chk("lock_c0_valid", 64'(a_mst_req_valid), 64'(1'b1));
    chk("lock_c0_op", 64'(a_mst_req_op), 64'(32'hA000_0002));
    chk("lock_c0_ready", 64'(a_req_ready), 64'(4'b0000));
    cyc(); a_drv(4'b0101, 1'b0); #1;
    chk("lock_c1_id", 64'(a_mst_req_id), 64'({2'd2, 5'd12}));
    chk("lock_c1_op", 64'(a_mst_req_op), 64'(32'hA000_0002));
    cyc(); a_drv(4'b0101, 1'b0); #1;
    chk("lock_c2_id", 64'(a_mst_req_id), 64'({2'd2, 5'd12}));
    cyc(); a_drv(4'b0101, 1'b1); #1;
    chk("lock_c3_ready", 64'(a_req_ready), 64'(4'b0100));
    cyc(); a_drv(4'b0101, 1'b1); #1;
    chk("lock_c4_id", 64'(a_mst_req_id), 64'({2'd0, 5'd10}));
    chk("lock_c4_ready", 64'(a_req_ready), 64'(4'b0001));
    cyc(); a_drv(4'b0000, 1'b0); a_rsp(1'b1, {2'd0, 5'd10}, 4'b1111); #1;
    chk("rsp_lane0_valid", 64'(a_rsp_valid), 64'(4'b0001));
    cyc(); a_rsp(1'b1, {2'd2, 5'd12}, 4'b1111); #1;
    chk("rsp_lane2_valid", 64'(a_rsp_valid), 64'(4'b0100));

    // Throttling of lane 1 at two in flight
    cyc(); a_drv(4'b0010, 1'b1); a_rsp(1'b0, 7'd0, 4'b1111); #1;
    chk("thr_a_ready", 64'(a_req_ready), 64'(4'b0010));
    cyc(); a_drv(4'b0010, 1'b1); #1;
    chk("thr_b_ready", 64'(a_req_ready), 64'(4'b0010));
    cyc(); a_drv(4'b1010, 1'b1); #1;
    chk("thr_c_ready", 64'(a_req_ready), 64'(4'b1000));
    chk("thr_c_id", 64'(a_mst_req_id), 64'({2'd3, 5'd13}));
    cyc(); a_drv(4'b0010, 1'b1); a_rsp(1'b1, {2'd1, 5'd11}, 4'b1111); #1;
    chk("thr_d_valid", 64'(a_mst_req_valid), 64'(1'b0));
    chk("thr_d_ready", 64'(a_req_ready), 64'(4'b0000));
    chk("thr_d_rsp", 64'(a_rsp_valid), 64'(4'b0010));
    cyc(); a_drv(4'b0010, 1'b1); a_rsp(1'b0, 7'd0, 4'b1111); #1;
    chk("thr_e_ready", 64'(a_req_ready), 64'(4'b0010));

    // Response routing to lane 3 with backpressure
    cyc(); a_drv(4'b0000, 1'b0); a_rsp(1'b1, {2'd3, 5'd7}, 4'b0111);
    a_mst_rsp_data = 32'hDEAD_BEEF; a_mst_rsp_err = 1'b1; #1;
    chk("route_valid", 64'(a_rsp_valid), 64'(4'b1000));
    chk("route_id", 64'(a_rsp_id[3]), 64'(5'd7));
    chk("route_data", 64'(a_rsp_data[3]), 64'(32'hDEAD_BEEF));
    chk("route_err", 64'(a_rsp_err[3]), 64'(1'b1));
    chk("route_stall", 64'(a_mst_rsp_ready), 64'(1'b0));
    cyc(); a_rsp(1'b1, {2'd3, 5'd7}, 4'b1111); #1;
    chk("route_go", 64'(a_mst_rsp_ready), 64'(1'b1));

    // Simultaneous request and response handshake on lane 0
    cyc(); a_drv(4'b0001, 1'b1); a_rsp(1'b0, 7'd0, 4'b1111); a_mst_rsp_err = 1'b0; #1;
    chk("sim_a_ready", 64'(a_req_ready), 64'(4'b0001));
    cyc(); a_drv(4'b0001, 1'b1); a_rsp(1'b1, {2'd0, 5'd10}, 4'b1111); #1;
    chk("sim_b_ready", 64'(a_req_ready), 64'(4'b0001));
    chk("sim_b_rsp", 64'(a_rsp_valid), 64'(4'b0001));
    cyc(); a_drv(4'b0001, 1'b1); a_rsp(1'b0, 7'd0, 4'b1111); #1;
    chk("sim_c_ready", 64'(a_req_ready), 64'(4'b0001));
    cyc(); a_drv(4'b0001, 1'b1); #1;
    chk("sim_d_ready", 64'(a_req_ready), 64'(4'b0000));
    chk("sim_d_valid", 64'(a_mst_req_valid), 64'(1'b0));

    // Asynchronous reset while locked with nonzero counters
    cyc(); a_drv(4'b0110, 1'b0); #1;
    chk("arst_pre_id", 64'(a_mst_req_id), 64'({2'd2, 5'd12}));
    cyc(); a_drv(4'b0011, 1'b1); #1;
    chk("arst_locked_valid", 64'(a_mst_req_valid), 64'(1'b0));
    #1; rst_n = 1'b0; #1;
    chk("arst_valid", 64'(a_mst_req_valid), 64'(1'b1));
    chk("arst_id", 64'(a_mst_req_id), 64'({2'd0, 5'd10}));
    chk("arst_ready", 64'(a_req_ready), 64'(4'b0001));
    a_drv(4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;

    // Three-lane instance: out-of-range index, routing, counter floor
    cyc(); b_rsp(1'b1, {2'd3, 5'd1}, 3'b000); #1;
    chk("b_oor_ready", 64'(b_mst_rsp_ready), 64'(1'b1));
    chk("b_oor_valid", 64'(b_rsp_valid), 64'(3'b000));
    cyc(); b_rsp(1'b1, {2'd2, 5'd9}, 3'b011); #1;
    chk("b_route_valid", 64'(b_rsp_valid), 64'(3'b100));
    chk("b_route_stall", 64'(b_mst_rsp_ready), 64'(1'b0));
    chk("b_route_id", 64'(b_rsp_id[2]), 64'(5'd9));
    cyc(); b_rsp(1'b1, {2'd1, 5'd0}, 3'b111); #1;
    chk("b_floor_rsp", 64'(b_rsp_valid), 64'(3'b010));
    cyc(); b_rsp(1'b0, 7'd0, 3'b111); b_req_valid = 3'b010; b_mst_req_ready = 1'b1; #1;
    chk("b_floor_ready", 64'(b_req_ready), 64'(3'b010));
    chk("b_floor_id", 64'(b_mst_req_id), 64'({2'd1, 5'd21}));
    cyc(); b_req_valid = 3'b111; #1;
    chk("b_rr_ready", 64'(b_req_ready), 64'(3'b100));
    cyc(); b_req_valid = 3'b000; b_mst_req_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
